ld_wb_ctrl: RTL and testbench

Write-back controller on the consumer side of the LD micro-instruction queue. Each LD micro-instruction is paired with one data vector from its selected source (host input stream or MFU result stream). The block issues the matching VRF write and optionally forwards the vector to the host output. It serialises completion so that `o_interrupt` fires only after every write and host transfer of the instruction has committed.

---
 rtl/npu_pkg.sv | 17 +
 rtl/ld_host_obuf.sv | 56 +++++
 rtl/ld_wb_ctrl.sv | 176 +++++++++++++++++
 tb/tb_ld_wb_ctrl.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// ----------------------------------------------------------------------------
// npu_pkg
// Shared encodings for the NPU LD write-back path.
//   SRC_HOST / SRC_MFU : values of the LD micro-instruction source select.
//   ld_state_e         : write-back controller states.
// ----------------------------------------------------------------------------
package npu_pkg;

    localparam logic SRC_HOST = 1'b0;
    localparam logic SRC_MFU  = 1'b1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } ld_state_e;

endpackage

// File: rtl/ld_host_obuf.sv
// ----------------------------------------------------------------------------
// ld_host_obuf
// One-entry valid/ready output register for the host output stream.
// A load and a drain may happen in the same cycle; the register then stays
// valid and holds the newly loaded word.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   i_load, i_data    : load request and word (caller guarantees room)
//   o_valid, o_data   : output word, held stable while o_valid & !i_rdy
//   i_rdy             : downstream ready
// ----------------------------------------------------------------------------
module ld_host_obuf #(
    parameter int DW = 320
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          i_rdy,
    output logic [DW-1:0] o_data
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        // Drain first, then a load overrides it so load+drain keeps valid.
        if (valid_q && i_rdy) begin
            valid_d = 1'b0;
        end
        if (i_load) begin
            valid_d = 1'b1;
            data_d  = i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Data needs no reset: it is only observed while valid_q is set.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;

endmodule

// File: rtl/ld_wb_ctrl.sv
// ----------------------------------------------------------------------------
// ld_wb_ctrl
// Consumer side of the LD micro-instruction queue. Pairs each LD uinst with
// one data vector from the host stream (src0) or the MFU stream (src1),
// issues the registered VRF write one cycle later, optionally forwards the
// vector to the host output, counts completed macro-instructions and raises
// a one-cycle interrupt only once all host traffic of the instruction has
// drained.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   i_uinst_*, o_uinst_rdy        : decoded LD uinst and its pop strobe
//   i_src0_* / o_src0_rdy         : host data stream
//   i_src1_* / o_src1_rdy         : MFU data stream
//   o_vrf_wr_en, o_vrf0/1_addr,
//   o_vrf_wr_data                 : registered VRF write port
//   o_host_valid/data, i_host_rdy : host output stream
//   o_interrupt                   : one-cycle completion pulse
//   o_inst_done                   : completed macro-instruction count (wraps)
//   o_busy                        : flushing or host word pending
// ----------------------------------------------------------------------------
module ld_wb_ctrl
    import npu_pkg::*;
#(
    parameter int DW    = 320,
    parameter int NVRF  = 4,
    parameter int VRFAW = 9,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_uinst_valid,
    output logic             o_uinst_rdy,
    input  logic [NVRF-1:0]  i_uinst_vrf_id,
    input  logic [VRFAW-1:0] i_uinst_vrf0_addr,
    input  logic [VRFAW-1:0] i_uinst_vrf1_addr,
    input  logic             i_uinst_src_sel,
    input  logic             i_uinst_last,
    input  logic             i_uinst_interrupt,
    input  logic             i_uinst_report_to_host,
    input  logic             i_src0_valid,
    output logic             o_src0_rdy,
    input  logic [DW-1:0]    i_src0_data,
    input  logic             i_src1_valid,
    output logic             o_src1_rdy,
    input  logic [DW-1:0]    i_src1_data,
    output logic [NVRF-1:0]  o_vrf_wr_en,
    output logic [VRFAW-1:0] o_vrf0_addr,
    output logic [VRFAW-1:0] o_vrf1_addr,
    output logic [DW-1:0]    o_vrf_wr_data,
    output logic             o_host_valid,
    input  logic             i_host_rdy,
    output logic [DW-1:0]    o_host_data,
    output logic             o_interrupt,
    output logic [CNTW-1:0]  o_inst_done,
    output logic             o_busy
);

    ld_state_e        state_q, state_d;
    logic [NVRF-1:0]  vrf_wr_en_q, vrf_wr_en_d;
    logic [VRFAW-1:0] vrf0_addr_q, vrf0_addr_d;
    logic [VRFAW-1:0] vrf1_addr_q, vrf1_addr_d;
    logic [DW-1:0]    wr_data_q, wr_data_d;
    logic [CNTW-1:0]  inst_done_q, inst_done_d;
    logic             interrupt_q, interrupt_d;

    logic             host_valid;
    logic             host_free;
    logic             src_valid;
    logic [DW-1:0]    src_data;
    logic             fire;

    // ------------------------------------------------------------------
    // Handshake: the uinst, its selected source and (if reporting) the
    // host register must all be ready for the pair to be consumed.
    // ------------------------------------------------------------------
    always_comb begin
        src_valid = (i_uinst_src_sel == SRC_MFU) ? i_src1_valid : i_src0_valid;
        src_data  = (i_uinst_src_sel == SRC_MFU) ? i_src1_data  : i_src0_data;
        host_free = !host_valid || i_host_rdy;
        fire      = (state_q == ST_RUN) && i_uinst_valid && src_valid &&
                    (!i_uinst_report_to_host || host_free);
    end

    assign o_uinst_rdy = fire;
    assign o_src0_rdy  = fire && (i_uinst_src_sel == SRC_HOST);
    assign o_src1_rdy  = fire && (i_uinst_src_sel == SRC_MFU);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        vrf_wr_en_d = '0;
        vrf0_addr_d = vrf0_addr_q;
        vrf1_addr_d = vrf1_addr_q;
        wr_data_d   = wr_data_q;
        inst_done_d = inst_done_q;
        interrupt_d = 1'b0;

        if (fire) begin
            vrf_wr_en_d = i_uinst_vrf_id;
            vrf0_addr_d = i_uinst_vrf0_addr;
            vrf1_addr_d = i_uinst_vrf1_addr;
            wr_data_d   = src_data;
            if (i_uinst_last) begin
                inst_done_d = inst_done_q + CNTW'(1);
            end
        end

        case (state_q)
            ST_RUN: begin
                // An interrupt bit on a non-last uinst is ignored.
                if (fire && i_uinst_last && i_uinst_interrupt) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Hold off new work until the host word of the final uinst
                // has left; the pulse then follows on the next cycle.
                if (!host_valid) begin
                    state_d     = ST_RUN;
                    interrupt_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control state and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            vrf_wr_en_q <= '0;
            inst_done_q <= '0;
            interrupt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vrf_wr_en_q <= vrf_wr_en_d;
            inst_done_q <= inst_done_d;
            interrupt_q <= interrupt_d;
        end
    end

    // Write address/data are qualified by o_vrf_wr_en, so no reset needed.
    always_ff @(posedge clk) begin
        vrf0_addr_q <= vrf0_addr_d;
        vrf1_addr_q <= vrf1_addr_d;
        wr_data_q   <= wr_data_d;
    end

    ld_host_obuf #(
        .DW (DW)
    ) u_host_obuf (
        .clk     (clk),
        .rst     (rst),
        .i_load  (fire && i_uinst_report_to_host),
        .i_data  (src_data),
        .o_valid (host_valid),
        .i_rdy   (i_host_rdy),
        .o_data  (o_host_data)
    );

    assign o_vrf_wr_en   = vrf_wr_en_q;
    assign o_vrf0_addr   = vrf0_addr_q;
    assign o_vrf1_addr   = vrf1_addr_q;
    assign o_vrf_wr_data = wr_data_q;
    assign o_host_valid  = host_valid;
    assign o_interrupt   = interrupt_q;
    assign o_inst_done   = inst_done_q;
    assign o_busy        = (state_q != ST_RUN) || host_valid;

endmodule

// File: tb/tb_ld_wb_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ld_wb_ctrl
// Directed bench for ld_wb_ctrl. The counter width is reduced to 8 bits so
// the wrap-around case is reachable in a few hundred cycles.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later
// (combinational rdys) or 1 ns after the next edge (registered outputs).
// ----------------------------------------------------------------------------
module tb_ld_wb_ctrl;

    localparam int DW    = 320;
    localparam int NVRF  = 4;
    localparam int VRFAW = 9;
    localparam int CNTW  = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_uinst_valid;
    logic             o_uinst_rdy;
    logic [NVRF-1:0]  i_uinst_vrf_id;
    logic [VRFAW-1:0] i_uinst_vrf0_addr;
    logic [VRFAW-1:0] i_uinst_vrf1_addr;
    logic             i_uinst_src_sel;
    logic             i_uinst_last;
    logic             i_uinst_interrupt;
    logic             i_uinst_report_to_host;
    logic             i_src0_valid;
    logic             o_src0_rdy;
    logic [DW-1:0]    i_src0_data;
    logic             i_src1_valid;
    logic             o_src1_rdy;
    logic [DW-1:0]    i_src1_data;
    logic [NVRF-1:0]  o_vrf_wr_en;
    logic [VRFAW-1:0] o_vrf0_addr;
    logic [VRFAW-1:0] o_vrf1_addr;
    logic [DW-1:0]    o_vrf_wr_data;
    logic             o_host_valid;
    logic             i_host_rdy;
    logic [DW-1:0]    o_host_data;
    logic             o_interrupt;
    logic [CNTW-1:0]  o_inst_done;
    logic             o_busy;

    int checks = 0;
    int errors = 0;
    logic [CNTW-1:0] exp_done = '0;

    always #5 clk = ~clk;

    ld_wb_ctrl #(
        .DW    (DW),
        .NVRF  (NVRF),
        .VRFAW (VRFAW),
        .CNTW  (CNTW)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .i_uinst_valid          (i_uinst_valid),
        .o_uinst_rdy            (o_uinst_rdy),
        .i_uinst_vrf_id         (i_uinst_vrf_id),
        .i_uinst_vrf0_addr      (i_uinst_vrf0_addr),
        .i_uinst_vrf1_addr      (i_uinst_vrf1_addr),
        .i_uinst_src_sel        (i_uinst_src_sel),
        .i_uinst_last           (i_uinst_last),
        .i_uinst_interrupt      (i_uinst_interrupt),
        .i_uinst_report_to_host (i_uinst_report_to_host),
        .i_src0_valid           (i_src0_valid),
        .o_src0_rdy             (o_src0_rdy),
        .i_src0_data            (i_src0_data),
        .i_src1_valid           (i_src1_valid),
        .o_src1_rdy             (o_src1_rdy),
        .i_src1_data            (i_src1_data),
        .o_vrf_wr_en            (o_vrf_wr_en),
        .o_vrf0_addr            (o_vrf0_addr),
        .o_vrf1_addr            (o_vrf1_addr),
        .o_vrf_wr_data          (o_vrf_wr_data),
        .o_host_valid           (o_host_valid),
        .i_host_rdy             (i_host_rdy),
        .o_host_data            (o_host_data),
        .o_interrupt            (o_interrupt),
        .o_inst_done            (o_inst_done),
        .o_busy                 (o_busy)
    );

    function automatic logic [DW-1:0] mk(input int i);
        logic [31:0] w;
        w = 32'hA500_0000 + 32'(i);
        return {10{w}};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        i_uinst_valid          = 1'b0;
        i_uinst_vrf_id         = '0;
        i_uinst_vrf0_addr      = '0;
        i_uinst_vrf1_addr      = '0;
        i_uinst_src_sel        = 1'b0;
        i_uinst_last           = 1'b0;
        i_uinst_interrupt      = 1'b0;
        i_uinst_report_to_host = 1'b0;
        i_src0_valid           = 1'b0;
        i_src0_data            = '0;
        i_src1_valid           = 1'b0;
        i_src1_data            = '0;
        i_host_rdy             = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (o_vrf_wr_en !== 4'b0000) begin errors++; $display("FAIL reset_wr_en got %b want 0000", o_vrf_wr_en); end
        checks++; if (o_host_valid !== 1'b0) begin errors++; $display("FAIL reset_host_valid got %b want 0", o_host_valid); end
        checks++; if (o_interrupt !== 1'b0) begin errors++; $display("FAIL reset_interrupt got %b want 0", o_interrupt); end
        checks++; if (o_inst_done !== 8'h00) begin errors++; $display("FAIL reset_inst_done got %h want 00", o_inst_done); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
        rst = 1'b0;
        tick();
        $display("reset: done, inst_done=%0d", o_inst_done);
    endtask

    // ------------------------------------------------------------------
    task automatic test_streaming;
        i_uinst_src_sel        = 1'b1;
        i_uinst_vrf_id         = 4'b0011;
        i_uinst_report_to_host = 1'b0;
        i_src1_valid           = 1'b1;
        i_uinst_valid          = 1'b1;
        for (int i = 0; i < 8; i++) begin
            i_uinst_vrf0_addr = VRFAW'(i);
            i_uinst_vrf1_addr = VRFAW'(i + 16);
            i_src1_data       = mk(i);
            #1;
            checks++; if (o_uinst_rdy !== 1'b1 || o_src1_rdy !== 1'b1 || o_src0_rdy !== 1'b0) begin
                errors++; $display("FAIL stream_rdy[%0d] got uinst=%b s0=%b s1=%b want 1 0 1", i, o_uinst_rdy, o_src0_rdy, o_src1_rdy);
            end
            tick();
            checks++; if (o_vrf_wr_en !== 4'b0011 || o_vrf0_addr !== VRFAW'(i) || o_vrf1_addr !== VRFAW'(i + 16)) begin
                errors++; $display("FAIL stream_write[%0d] got en=%b a0=%0d a1=%0d want 0011 %0d %0d", i, o_vrf_wr_en, o_vrf0_addr, o_vrf1_addr, i, i + 16);
            end
            checks++; if (o_vrf_wr_data !== mk(i) || o_host_valid !== 1'b0) begin
                errors++; $display("FAIL stream_data[%0d] got data=%h hv=%b want %h 0", i, o_vrf_wr_data[31:0], o_host_valid, mk(i) & 320'hFFFF_FFFF);
            end
            $display("stream: uinst %0d written addr0=%0d", i, o_vrf0_addr);
        end
        i_uinst_valid = 1'b0;
        i_src1_valid  = 1'b0;
        tick();
        checks++; if (o_vrf_wr_en !== 4'b0000) begin errors++; $display("FAIL stream_idle_wr_en got %b want 0000", o_vrf_wr_en); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_source_isolation;
        i_uinst_src_sel = 1'b0;
        i_uinst_vrf_id  = 4'b0100;
        i_uinst_vrf1_addr = 9'd33;
        i_src1_valid    = 1'b1;
        i_src1_data     = mk(50);
        i_src0_valid    = 1'b0;
        i_src0_data     = mk(51);
        i_uinst_valid   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (o_uinst_rdy !== 1'b0 || o_src0_rdy !== 1'b0 || o_src1_rdy !== 1'b0) begin
                errors++; $display("FAIL iso_wait[%0d] got uinst=%b s0=%b s1=%b want 0 0 0", c, o_uinst_rdy, o_src0_rdy, o_src1_rdy);
            end
            tick();
            checks++; if (o_vrf_wr_en !== 4'b0000) begin errors++; $display("FAIL iso_nowrite[%0d] got %b want 0000", c, o_vrf_wr_en); end
        end
        i_src0_valid = 1'b1;
        #1;
        checks++; if (o_uinst_rdy !== 1'b1 || o_src0_rdy !== 1'b1 || o_src1_rdy !== 1'b0) begin
            errors++; $display("FAIL iso_fire got uinst=%b s0=%b s1=%b want 1 1 0", o_uinst_rdy, o_src0_rdy, o_src1_rdy);
        end
        tick();
        i_uinst_valid = 1'b0;
        i_src0_valid  = 1'b0;
        i_src1_valid  = 1'b0;
        checks++; if (o_vrf_wr_en !== 4'b0100 || o_vrf1_addr !== 9'd33 || o_vrf_wr_data !== mk(51)) begin
            errors++; $display("FAIL iso_write got en=%b a1=%0d data=%h want 0100 33 a5000033", o_vrf_wr_en, o_vrf1_addr, o_vrf_wr_data[31:0]);
        end
        $display("isolation: host-source uinst fired after 3 wait cycles");
    endtask

    // ------------------------------------------------------------------
    task automatic test_host_backpressure;
        logic [DW-1:0] q[$];
        logic [DW-1:0] exp_w;
        int k = 0;
        int delivered = 0;
        logic exp_fire;
        i_uinst_src_sel        = 1'b1;
        i_uinst_vrf_id         = 4'b1000;
        i_uinst_report_to_host = 1'b1;
        i_src1_valid           = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            i_uinst_valid     = (k < 4);
            i_src1_data       = mk(100 + k);
            i_uinst_vrf1_addr = VRFAW'(k);
            i_host_rdy        = (cyc >= 5);
            #1;
            // Host register empty at cycle 0; stalled by rdy low through cycle 4.
            exp_fire = (k < 4) && (cyc == 0 || cyc >= 5);
            checks++; if (o_uinst_rdy !== exp_fire) begin
                errors++; $display("FAIL bp_fire[cyc%0d] got %b want %b", cyc, o_uinst_rdy, exp_fire);
            end
            if (o_host_valid && i_host_rdy) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL bp_extra_word[cyc%0d] got %h want none", cyc, o_host_data[31:0]);
                end else begin
                    exp_w = q.pop_front();
                    if (o_host_data !== exp_w) begin
                        errors++; $display("FAIL bp_word[%0d] got %h want %h", delivered, o_host_data[31:0], exp_w[31:0]);
                    end
                end
                $display("backpressure: host word %0d delivered at cycle %0d", delivered, cyc);
                delivered++;
            end
            if (o_uinst_rdy) begin
                q.push_back(mk(100 + k));
                k++;
            end
            tick();
        end
        i_uinst_valid = 1'b0;
        i_src1_valid  = 1'b0;
        i_uinst_report_to_host = 1'b0;
        i_host_rdy    = 1'b0;
        checks++; if (delivered != 4 || q.size() != 0) begin
            errors++; $display("FAIL bp_count got delivered=%0d pending=%0d want 4 0", delivered, q.size());
        end
        checks++; if (o_host_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b want 0", o_host_valid); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_interrupt_flush;
        i_uinst_src_sel        = 1'b0;
        i_uinst_vrf_id         = 4'b0001;
        i_src0_valid           = 1'b1;
        i_src0_data            = mk(200);
        i_uinst_report_to_host = 1'b1;
        i_uinst_last           = 1'b1;
        i_uinst_interrupt      = 1'b1;
        i_host_rdy             = 1'b0;
        i_uinst_valid          = 1'b1;
        #1;
        checks++; if (o_uinst_rdy !== 1'b1 || o_src0_rdy !== 1'b1) begin
            errors++; $display("FAIL irq_fire got uinst=%b s0=%b want 1 1", o_uinst_rdy, o_src0_rdy);
        end
        tick();
        exp_done = exp_done + 8'd1;
        // A follow-on plain uinst is offered throughout the flush.
        i_uinst_report_to_host = 1'b0;
        i_uinst_last           = 1'b0;
        i_uinst_interrupt      = 1'b0;
        i_src0_data            = mk(201);
        for (int c = 1; c <= 3; c++) begin
            #1;
            checks++; if (o_uinst_rdy !== 1'b0 || o_busy !== 1'b1 || o_interrupt !== 1'b0 || o_host_valid !== 1'b1) begin
                errors++; $display("FAIL irq_flush[%0d] got rdy=%b busy=%b irq=%b hv=%b want 0 1 0 1", c, o_uinst_rdy, o_busy, o_interrupt, o_host_valid);
            end
            tick();
        end
        checks++; if (o_inst_done !== exp_done) begin errors++; $display("FAIL irq_count got %0d want %0d", o_inst_done, exp_done); end
        i_host_rdy = 1'b1;
        #1;
        checks++; if (o_uinst_rdy !== 1'b0 || o_host_data !== mk(200)) begin
            errors++; $display("FAIL irq_drain got rdy=%b data=%h want 0 %h", o_uinst_rdy, o_host_data[31:0], 32'hA50000C8);
        end
        tick();
        i_host_rdy = 1'b0;
        #1;
        checks++; if (o_host_valid !== 1'b0 || o_uinst_rdy !== 1'b0 || o_interrupt !== 1'b0 || o_busy !== 1'b1) begin
            errors++; $display("FAIL irq_exit got hv=%b rdy=%b irq=%b busy=%b want 0 0 0 1", o_host_valid, o_uinst_rdy, o_interrupt, o_busy);
        end
        tick();
        #1;
        checks++; if (o_interrupt !== 1'b1 || o_busy !== 1'b0 || o_uinst_rdy !== 1'b1) begin
            errors++; $display("FAIL irq_pulse got irq=%b busy=%b rdy=%b want 1 0 1", o_interrupt, o_busy, o_uinst_rdy);
        end
        $display("flush: interrupt pulse, inst_done=%0d", o_inst_done);
        tick();
        i_uinst_valid = 1'b0;
        i_src0_valid  = 1'b0;
        checks++; if (o_interrupt !== 1'b0 || o_vrf_wr_en !== 4'b0001 || o_vrf_wr_data !== mk(201)) begin
            errors++; $display("FAIL irq_after got irq=%b en=%b data=%h want 0 0001 a50000c9", o_interrupt, o_vrf_wr_en, o_vrf_wr_data[31:0]);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_edge_cases;
        // vrf_id == 0: consumed, no write
        i_uinst_src_sel = 1'b1;
        i_uinst_vrf_id  = 4'b0000;
        i_src1_valid    = 1'b1;
        i_src1_data     = mk(400);
        i_uinst_valid   = 1'b1;
        #1;
        checks++; if (o_uinst_rdy !== 1'b1 || o_src1_rdy !== 1'b1) begin
            errors++; $display("FAIL zero_id_pop got uinst=%b s1=%b want 1 1", o_uinst_rdy, o_src1_rdy);
        end
        tick();
        checks++; if (o_vrf_wr_en !== 4'b0000) begin errors++; $display("FAIL zero_id_write got %b want 0000", o_vrf_wr_en); end
        $display("edge: vrf_id=0 uinst popped");

        // last without interrupt
        i_uinst_vrf_id = 4'b0010;
        i_uinst_last   = 1'b1;
        tick();
        exp_done = exp_done + 8'd1;
        i_uinst_valid = 1'b0;
        i_uinst_last  = 1'b0;
        checks++; if (o_inst_done !== exp_done || o_vrf_wr_en !== 4'b0010 || o_busy !== 1'b0) begin
            errors++; $display("FAIL last_noirq got cnt=%0d en=%b busy=%b want %0d 0010 0", o_inst_done, o_vrf_wr_en, o_busy, exp_done);
        end
        tick();
        checks++; if (o_interrupt !== 1'b0) begin errors++; $display("FAIL last_noirq_pulse1 got %b want 0", o_interrupt); end
        tick();
        checks++; if (o_interrupt !== 1'b0) begin errors++; $display("FAIL last_noirq_pulse2 got %b want 0", o_interrupt); end
        $display("edge: last without interrupt, inst_done=%0d", o_inst_done);

        // interrupt without last: ignored
        i_uinst_valid     = 1'b1;
        i_uinst_interrupt = 1'b1;
        tick();
        i_uinst_interrupt = 1'b0;
        #1;
        checks++; if (o_uinst_rdy !== 1'b1 || o_busy !== 1'b0) begin
            errors++; $display("FAIL irq_nolast_run got rdy=%b busy=%b want 1 0", o_uinst_rdy, o_busy);
        end
        tick();
        i_uinst_valid = 1'b0;
        checks++; if (o_interrupt !== 1'b0 || o_inst_done !== exp_done) begin
            errors++; $display("FAIL irq_nolast got irq=%b cnt=%0d want 0 %0d", o_interrupt, o_inst_done, exp_done);
        end
        tick();
        checks++; if (o_interrupt !== 1'b0) begin errors++; $display("FAIL irq_nolast_pulse got %b want 0", o_interrupt); end
        i_src1_valid = 1'b0;
        $display("edge: interrupt without last ignored");
    endtask

    // ------------------------------------------------------------------
    task automatic test_count_wrap;
        i_uinst_src_sel = 1'b1;
        i_uinst_vrf_id  = 4'b0001;
        i_src1_valid    = 1'b1;
        i_uinst_last    = 1'b1;
        i_uinst_valid   = 1'b1;
        for (int n = 0; n < 300 && exp_done != 8'hFF; n++) begin
            tick();
            exp_done = exp_done + 8'd1;
        end
        i_uinst_valid = 1'b0;
        #1;
        checks++; if (o_inst_done !== 8'hFF) begin errors++; $display("FAIL wrap_max got %h want ff", o_inst_done); end
        i_uinst_valid = 1'b1;
        tick();
        exp_done = exp_done + 8'd1;
        i_uinst_valid = 1'b0;
        i_uinst_last  = 1'b0;
        i_src1_valid  = 1'b0;
        checks++; if (o_inst_done !== 8'h00) begin errors++; $display("FAIL wrap_zero got %h want 00", o_inst_done); end
        $display("wrap: inst_done=%0d after max", o_inst_done);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_in_flush;
        i_uinst_src_sel        = 1'b0;
        i_uinst_vrf_id         = 4'b0001;
        i_src0_valid           = 1'b1;
        i_src0_data            = mk(500);
        i_uinst_report_to_host = 1'b1;
        i_uinst_last           = 1'b1;
        i_uinst_interrupt      = 1'b1;
        i_host_rdy             = 1'b0;
        i_uinst_valid          = 1'b1;
        tick();
        idle_inputs();
        #1;
        checks++; if (o_busy !== 1'b1 || o_host_valid !== 1'b1) begin
            errors++; $display("FAIL rstf_pending got busy=%b hv=%b want 1 1", o_busy, o_host_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_done = '0;
        checks++; if (o_host_valid !== 1'b0 || o_interrupt !== 1'b0 || o_busy !== 1'b0 || o_inst_done !== exp_done) begin
            errors++; $display("FAIL rstf_state got hv=%b irq=%b busy=%b cnt=%0d want 0 0 0 0", o_host_valid, o_interrupt, o_busy, o_inst_done);
        end
        tick();
        checks++; if (o_interrupt !== 1'b0) begin errors++; $display("FAIL rstf_nopulse got %b want 0", o_interrupt); end
        i_uinst_valid     = 1'b1;
        i_uinst_vrf_id    = 4'b0101;
        i_uinst_vrf0_addr = 9'd7;
        i_uinst_vrf1_addr = 9'd9;
        i_src0_valid      = 1'b1;
        i_src0_data       = mk(501);
        #1;
        checks++; if (o_uinst_rdy !== 1'b1) begin errors++; $display("FAIL rstf_refire got %b want 1", o_uinst_rdy); end
        tick();
        idle_inputs();
        checks++; if (o_vrf_wr_en !== 4'b0101 || o_vrf0_addr !== 9'd7 || o_vrf1_addr !== 9'd9 || o_vrf_wr_data !== mk(501)) begin
            errors++; $display("FAIL rstf_write got en=%b a0=%0d a1=%0d data=%h want 0101 7 9 a50001f5", o_vrf_wr_en, o_vrf0_addr, o_vrf1_addr, o_vrf_wr_data[31:0]);
        end
        $display("reset-in-flush: recovered, new uinst written");
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_streaming();
        test_source_isolation();
        test_host_backpressure();
        test_interrupt_flush();
        test_edge_cases();
        test_count_wrap();
        test_reset_in_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
